freq_meter_ctrl: RTL

FREQ_METER_CTRL -- requirements
Module: freq_meter_ctrl

---
 rtl/freq_meter_pkg.sv | 24 ++
 rtl/freq_meter_ctrl_edge_sync.sv | 18 +
 rtl/freq_meter_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and width helpers for the gated-window frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_HOLD = 2'd2
  } fm_state_e;

  // Bits needed to hold 0..v, never less than one.
  function automatic int w_of(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int freq_width(input int max_freq);
    return $clog2(max_freq + 1);
  endfunction

  // One count beyond the clamp point, so saturation still reads as overflow.
  function automatic int edge_cnt_width(input int max_freq, input int scale);
    return w_of(max_freq / scale + 1);
  endfunction

endpackage

// File: rtl/freq_meter_ctrl_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector: one-cycle pulse per signal rise.
module edge_sync (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic signal_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], signal_i};
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_meter_ctrl.sv
// Frequency meter: counts synchronized edges over a fixed gate window and
// reports edges*SCALE clamped to MAX_FREQ, with ack/continuous handshake.
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int GATE_CYCLES = 50000000,
  parameter int MAX_FREQ    = 1000000
) (
  input  logic                              clk_i,
  input  logic                              arstn_i,
  input  logic                              signal_i,
  input  logic                              start_i,
  input  logic                              cont_i,
  input  logic                              abort_i,
  input  logic                              ack_i,
  output logic                              busy_o,
  output logic                              valid_o,
  output logic [freq_width(MAX_FREQ)-1:0]   freq_o,
  output logic                              ovf_o
);

  localparam int SCALE      = CLK_FREQ / GATE_CYCLES;
  localparam int FREQ_WIDTH = freq_width(MAX_FREQ);
  localparam int ECW        = edge_cnt_width(MAX_FREQ, (SCALE < 1) ? 1 : SCALE);
  localparam int GCW        = w_of(GATE_CYCLES - 1);

  if ((CLK_FREQ % GATE_CYCLES) != 0 || SCALE < 1) begin : g_bad_params
    $error("freq_meter_ctrl: CLK_FREQ must be a positive multiple of GATE_CYCLES");
  end

  fm_state_e        state_q, state_d;
  logic [GCW-1:0]   gate_cnt_q;
  logic [ECW-1:0]   edge_cnt_q, edge_inc;
  logic             edge_pulse;
  logic             load_win, end_win, clr_valid;
  logic [63:0]      prod;
  logic             clamp;

  edge_sync u_edge_sync (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .signal_i (signal_i),
    .pulse_o  (edge_pulse)
  );

  always_comb begin
    state_d   = state_q;
    load_win  = 1'b0;
    end_win   = 1'b0;
    clr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort_i && start_i) begin
          state_d  = ST_GATE;
          load_win = 1'b1;
        end
      end
      ST_GATE: begin
        if (abort_i) begin
          state_d   = ST_IDLE;
          clr_valid = 1'b1;
        end else if (gate_cnt_q == '0) begin
          state_d = ST_HOLD;
          end_win = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort_i) begin
          state_d   = ST_IDLE;
          clr_valid = 1'b1;
        end else if (ack_i) begin
          clr_valid = 1'b1;
          if (cont_i) begin
            state_d  = ST_GATE;
            load_win = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge in the final gate cycle is folded in through edge_inc.
  always_comb begin
    edge_inc = edge_cnt_q;
    if (edge_pulse && (edge_cnt_q != '1)) edge_inc = edge_cnt_q + ECW'(1);
  end

  assign prod  = 64'(edge_inc) * 64'(SCALE);
  assign clamp = prod > 64'(MAX_FREQ);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= ST_IDLE;
      busy_o     <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      valid_o    <= 1'b0;
      freq_o     <= '0;
      ovf_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d != ST_IDLE);
      if (load_win) begin
        gate_cnt_q <= GCW'(GATE_CYCLES - 1);
        edge_cnt_q <= '0;
      end else if (state_q == ST_GATE) begin
        if (gate_cnt_q != '0) gate_cnt_q <= gate_cnt_q - GCW'(1);
        edge_cnt_q <= edge_inc;
      end
      if (end_win) begin
        freq_o  <= clamp ? FREQ_WIDTH'(MAX_FREQ) : prod[FREQ_WIDTH-1:0];
        ovf_o   <= clamp;
        valid_o <= 1'b1;
      end
      if (clr_valid || load_win) valid_o <= 1'b0;
    end
  end

endmodule
